// File: rtl/tile_scheduler_pkg.sv
// Shared types and helpers for the systolic matmul tile scheduler.
// Holds the FSM state encoding and the default array geometry.
package tpu_pkg;

  localparam int ARR_DEF = 5;
  localparam int WORD_SIZE = 8 * ARR_DEF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic int unsigned ceil_div(
    input int unsigned a,
    input int unsigned b
  );
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Control bundle between the host handshake, the scheduler
// and the A/B/OUT global-buffer ports.
interface tile_scheduler_if
  import tpu_pkg::*;
#(
  parameter int ARR    = ARR_DEF,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
);
  localparam int RW = (ARR > 1) ? $clog2(ARR) : 1;

  logic              start;
  logic [DIM_W-1:0]  m;
  logic [DIM_W-1:0]  k;
  logic [DIM_W-1:0]  n;
  logic              busy;
  logic              done;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [RW-1:0]     b_row_sel;
  logic              b_pad;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic              o_acc;
  logic [ARR-1:0]    o_col_mask;

  modport master (
    output start, m, k, n,
    input  busy, done,
    input  b_rd_en, b_rd_addr, b_row_sel, b_pad,
    input  a_rd_en, a_rd_addr,
    input  o_wr_en, o_wr_addr, o_acc, o_col_mask
  );

  modport slave (
    input  start, m, k, n,
    output busy, done,
    output b_rd_en, b_rd_addr, b_row_sel, b_pad,
    output a_rd_en, a_rd_addr,
    output o_wr_en, o_wr_addr, o_acc, o_col_mask
  );

endinterface

// File: rtl/tile_scheduler_wr_delay_line.sv
// Fixed-latency shift line carrying output-buffer write commands
// from the A read issue point to the array drain point.
module wr_delay_line
  import tpu_pkg::*;
#(
  parameter int DEPTH  = 9,
  parameter int ADDR_W = 16,
  parameter int ARR    = ARR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_acc,
  input  logic [ARR-1:0]    in_mask,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_acc,
  output logic [ARR-1:0]    out_mask,
  output logic              empty
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              acc;
    logic [ARR-1:0]    mask;
  } ent_t;

  ent_t           line [DEPTH];
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;

  // empty means nothing is left in flight once this edge has shifted
  assign cnt_n = cnt + CW'(in_valid) - CW'(line[DEPTH-1].valid);
  assign empty = (cnt_n == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else begin
      cnt <= cnt_n;
      line[0] <= {in_valid, in_addr, in_acc, in_mask};
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign out_valid = line[DEPTH-1].valid;
  assign out_addr  = line[DEPTH-1].addr;
  assign out_acc   = line[DEPTH-1].acc;
  assign out_mask  = line[DEPTH-1].mask;

endmodule

// File: rtl/tile_scheduler.sv
// Tiled K/N sequencer for the weight-stationary systolic array:
// weight loads, activation streaming and delayed output writes.
module tile_scheduler
  import tpu_pkg::*;
#(
  parameter int ARR      = ARR_DEF,
  parameter int DIM_W    = 8,
  parameter int ADDR_W   = 16,
  parameter int PIPE_LAT = 2 * ARR - 1
) (
  input logic             clk,
  input logic             rst,
  tile_scheduler_if.slave bus
);
  localparam int RW = (ARR > 1) ? $clog2(ARR) : 1;
  localparam logic [DIM_W-1:0] LAST_R = DIM_W'(ARR - 1);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t st, st_n;
  logic [DIM_W-1:0] idx, idx_n;
  logic [DIM_W-1:0] kt, kt_n;
  logic [DIM_W-1:0] nt, nt_n;
  logic [DIM_W-1:0] m_q, m_n;
  logic [DIM_W-1:0] k_q, k_n;
  logic [DIM_W-1:0] n_q, n_n;
  logic [DIM_W-1:0] kt_tot, kt_tot_n;
  logic [DIM_W-1:0] nt_tot, nt_tot_n;

  logic              busy_q, done_q;
  logic              b_en_q, b_pad_q;
  logic [RW-1:0]     b_sel_q;
  logic [ADDR_W-1:0] b_addr_q;
  logic              a_en_q;
  logic [ADDR_W-1:0] a_addr_q;
  logic [ADDR_W-1:0] p_addr_q;
  logic              p_acc_q;
  logic [ARR-1:0]    p_mask_q;

  logic              ld_n, sm_n, pad_n;
  logic [31:0]       kk_n;
  logic [ADDR_W-1:0] b_addr_n, a_addr_n, p_addr_n;
  logic [ARR-1:0]    mask_n;

  logic              dl_empty;
  logic              wr_en, wr_acc;
  logic [ADDR_W-1:0] wr_addr;
  logic [ARR-1:0]    wr_mask;

  always_comb begin
    st_n     = st;
    idx_n    = idx;
    kt_n     = kt;
    nt_n     = nt;
    m_n      = m_q;
    k_n      = k_q;
    n_n      = n_q;
    kt_tot_n = kt_tot;
    nt_tot_n = nt_tot;
    unique case (st)
      S_IDLE: begin
        if (bus.start) begin
          m_n      = bus.m;
          k_n      = bus.k;
          n_n      = bus.n;
          kt_tot_n = DIM_W'(ceil_div(32'(bus.k), ARR));
          nt_tot_n = DIM_W'(ceil_div(32'(bus.n), ARR));
          idx_n    = '0;
          kt_n     = '0;
          nt_n     = '0;
          st_n     = (bus.m == '0 || bus.k == '0 || bus.n == '0)
                     ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (idx == LAST_R) begin
          idx_n = '0;
          st_n  = S_STREAM;
        end else begin
          idx_n = idx + ONE;
        end
      end
      S_STREAM: begin
        if (idx == m_q - ONE) begin
          idx_n = '0;
          st_n  = S_DRAIN;
        end else begin
          idx_n = idx + ONE;
        end
      end
      S_DRAIN: begin
        if (dl_empty) begin
          if (kt == kt_tot - ONE) begin
            kt_n = '0;
            if (nt == nt_tot - ONE) begin
              st_n = S_DONE;
            end else begin
              nt_n = nt + ONE;
              st_n = S_LOAD_W;
            end
          end else begin
            kt_n = kt + ONE;
            st_n = S_LOAD_W;
          end
        end
      end
      S_DONE:  st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

  // outputs are precomputed from next-state so they land registered
  always_comb begin
    ld_n     = (st_n == S_LOAD_W);
    sm_n     = (st_n == S_STREAM);
    kk_n     = 32'(kt_n) * 32'(ARR) + 32'(idx_n);
    pad_n    = (kk_n >= 32'(k_n));
    b_addr_n = ADDR_W'(32'(nt_n) * 32'(k_n) + kk_n);
    a_addr_n = ADDR_W'(32'(kt_n) * 32'(m_n) + 32'(idx_n));
    p_addr_n = ADDR_W'(32'(nt_n) * 32'(m_n) + 32'(idx_n));
    mask_n   = '0;
    for (int j = 0; j < ARR; j++) begin
      mask_n[j] = (32'(nt_n) * 32'(ARR) + 32'(j)) < 32'(n_n);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= S_IDLE;
      idx      <= '0;
      kt       <= '0;
      nt       <= '0;
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      kt_tot   <= '0;
      nt_tot   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      b_en_q   <= 1'b0;
      b_pad_q  <= 1'b0;
      b_sel_q  <= '0;
      b_addr_q <= '0;
      a_en_q   <= 1'b0;
      a_addr_q <= '0;
      p_addr_q <= '0;
      p_acc_q  <= 1'b0;
      p_mask_q <= '0;
    end else begin
      st       <= st_n;
      idx      <= idx_n;
      kt       <= kt_n;
      nt       <= nt_n;
      m_q      <= m_n;
      k_q      <= k_n;
      n_q      <= n_n;
      kt_tot   <= kt_tot_n;
      nt_tot   <= nt_tot_n;
      busy_q   <= ld_n || sm_n || (st_n == S_DRAIN);
      done_q   <= (st_n == S_DONE);
      b_en_q   <= ld_n && !pad_n;
      b_pad_q  <= ld_n && pad_n;
      b_sel_q  <= ld_n ? idx_n[RW-1:0] : '0;
      b_addr_q <= (ld_n && !pad_n) ? b_addr_n : '0;
      a_en_q   <= sm_n;
      a_addr_q <= sm_n ? a_addr_n : '0;
      p_addr_q <= sm_n ? p_addr_n : '0;
      p_acc_q  <= sm_n && (kt_n != '0);
      p_mask_q <= sm_n ? mask_n : '0;
    end
  end

  wr_delay_line #(
    .DEPTH (PIPE_LAT),
    .ADDR_W(ADDR_W),
    .ARR   (ARR)
  ) u_dl (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_en_q),
    .in_addr  (p_addr_q),
    .in_acc   (p_acc_q),
    .in_mask  (p_mask_q),
    .out_valid(wr_en),
    .out_addr (wr_addr),
    .out_acc  (wr_acc),
    .out_mask (wr_mask),
    .empty    (dl_empty)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.b_rd_en    = b_en_q;
  assign bus.b_rd_addr  = b_addr_q;
  assign bus.b_row_sel  = b_sel_q;
  assign bus.b_pad      = b_pad_q;
  assign bus.a_rd_en    = a_en_q;
  assign bus.a_rd_addr  = a_addr_q;
  assign bus.o_wr_en    = wr_en;
  assign bus.o_wr_addr  = wr_addr;
  assign bus.o_acc      = wr_acc;
  assign bus.o_col_mask = wr_mask;

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: a pass-level timing model
// queues expected strobes, a negedge monitor pops and compares.
module tb_tile_scheduler;
  import tpu_pkg::*;

  localparam int ARR    = 5;
  localparam int DIM_W  = 8;
  localparam int ADDR_W = 16;
  localparam int PL     = 2 * ARR - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_scheduler_if #(.ARR(ARR), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  tile_scheduler #(
    .ARR(ARR), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .PIPE_LAT(PL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int cyc;
    int addr;
    int sel;
    bit pad;
    bit acc;
    int mask;
  } ev_t;

  ev_t qb[$];
  ev_t qa[$];
  ev_t qo[$];
  int  qd[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int busy_lo = 0;
  int busy_hi = 0;
  int idle_from = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  // Expected trace of one job accepted at cycle c0, built pass by pass.
  task automatic model_job(input int c0, input int mm,
                           input int kk, input int nn);
    int t = c0 + 1;
    if (mm == 0 || kk == 0 || nn == 0) begin
      qd.push_back(t);
      busy_lo = t;
      busy_hi = t;
      idle_from = t + 1;
      return;
    end
    for (int nt = 0; nt < (nn + ARR - 1) / ARR; nt++) begin
      for (int kt = 0; kt < (kk + ARR - 1) / ARR; kt++) begin
        for (int r = 0; r < ARR; r++) begin
          int row = kt * ARR + r;
          qb.push_back('{cyc: t + r, addr: (nt * kk + row) % 65536,
                         sel: r, pad: (row >= kk), acc: 0, mask: 0});
        end
        for (int i = 0; i < mm; i++) begin
          int msk = 0;
          for (int j = 0; j < ARR; j++)
            if (nt * ARR + j < nn) msk |= (1 << j);
          qa.push_back('{cyc: t + ARR + i, addr: kt * mm + i,
                         sel: 0, pad: 0, acc: 0, mask: 0});
          qo.push_back('{cyc: t + ARR + i + PL, addr: nt * mm + i,
                         sel: 0, pad: 0, acc: (kt != 0), mask: msk});
        end
        t += ARR + mm + PL;
      end
    end
    qd.push_back(t);
    busy_lo = c0 + 1;
    busy_hi = t;
    idle_from = t + 1;
  endtask

  bit  eb, ea, eo, ed;
  ev_t e;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ctrl", int'({bus.busy, bus.done, bus.b_rd_en, bus.b_pad,
                            bus.b_row_sel, bus.a_rd_en, bus.o_wr_en,
                            bus.o_acc, bus.o_col_mask}), 0);
      chk("rst_addr", int'({bus.b_rd_addr, bus.a_rd_addr}), 0);
      chk("rst_oaddr", int'(bus.o_wr_addr), 0);
    end else begin
      chk("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc < busy_hi));

      eb = qb.size() > 0 && qb[0].cyc == cyc;
      chk("b_strobe", int'(bus.b_rd_en | bus.b_pad), int'(eb));
      if (eb) begin
        e = qb.pop_front();
        if (bus.b_rd_en | bus.b_pad) begin
          chk("b_pad", int'(bus.b_pad), int'(e.pad));
          chk("b_rd_en", int'(bus.b_rd_en), int'(!e.pad));
          chk("b_row_sel", int'(bus.b_row_sel), e.sel);
          if (!e.pad) chk("b_rd_addr", int'(bus.b_rd_addr), e.addr);
        end
      end

      ea = qa.size() > 0 && qa[0].cyc == cyc;
      chk("a_rd_en", int'(bus.a_rd_en), int'(ea));
      if (ea) begin
        e = qa.pop_front();
        if (bus.a_rd_en) chk("a_rd_addr", int'(bus.a_rd_addr), e.addr);
      end

      eo = qo.size() > 0 && qo[0].cyc == cyc;
      chk("o_wr_en", int'(bus.o_wr_en), int'(eo));
      if (eo) begin
        e = qo.pop_front();
        if (bus.o_wr_en) begin
          chk("o_wr_addr", int'(bus.o_wr_addr), e.addr);
          chk("o_acc", int'(bus.o_acc), int'(e.acc));
          chk("o_col_mask", int'(bus.o_col_mask), e.mask);
        end
      end

      ed = qd.size() > 0 && qd[0] == cyc;
      chk("done", int'(bus.done), int'(ed));
      if (ed) void'(qd.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Busy-time stimulus: start pulses and dim changes must be ignored.
  task automatic noise(input bit hold);
    bus.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
    bus.m = 8'($urandom);
    bus.k = 8'($urandom);
    bus.n = 8'($urandom);
  endtask

  task automatic issue(input int mm, input int kk, input int nn);
    bus.start = 1'b1;
    bus.m = 8'(mm);
    bus.k = 8'(kk);
    bus.n = 8'(nn);
    model_job(cyc, mm, kk, nn);
    tick();
  endtask

  task automatic run_job(input int mm, input int kk, input int nn,
                         input bit hold);
    while (cyc < idle_from) begin
      noise(hold);
      tick();
    end
    if (!hold && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        bus.start = 1'b0;
        tick();
      end
    end
    issue(mm, kk, nn);
  endtask

  int c0;

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.m = '0;
    bus.k = '0;
    bus.n = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    run_job(5, 5, 5, 1'b0);
    run_job(7, 12, 6, 1'b0);
    run_job(5, 0, 5, 1'b0);
    run_job(5, 5, 5, 1'b1);
    run_job(3, 7, 4, 1'b1);
    run_job(1, 1, 1, 1'b0);

    while (cyc < idle_from) begin
      noise(1'b0);
      tick();
    end
    bus.start = 1'b0;
    tick();
    issue(5, 5, 5);
    c0 = cyc - 1;
    while (cyc < c0 + 12) begin
      noise(1'b0);
      tick();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    qb.delete();
    qa.delete();
    qo.delete();
    qd.delete();
    busy_lo = 0;
    busy_hi = 0;
    idle_from = 0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (15) tick();
    run_job(5, 5, 5, 1'b0);

    for (int j = 0; j < 16; j++) begin
      run_job($urandom_range(1, 9), $urandom_range(0, 14),
              $urandom_range(1, 12), 1'($urandom_range(0, 1)));
    end

    while (cyc < idle_from + 3) begin
      bus.start = 1'b0;
      tick();
    end
    chk("qb_left", qb.size(), 0);
    chk("qa_left", qa.size(), 0);
    chk("qo_left", qo.size(), 0);
    chk("qd_left", qd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
